// File: rtl/aes_key_sched.sv
// aes_key_sched -- iterative AES-128 key expansion engine.
//
// Accepts a 128-bit cipher key (word w0 in [127:96]) and streams round
// keys 0..NROUNDS to the round datapath over a valid/ready handshake.
// SubWord(RotWord(w3)) comes from a registered four-byte S-box (aes_sbox4,
// one cycle of latency). Each key is presented in EMIT for at least one
// cycle, which gives the S-box register time to capture w3. The following
// single-cycle EXPAND step then derives the next key from that value.
//
// Ports:
//   clk, nreset         clock, asynchronous active-low reset
//   key_valid/key_ready key handshake (key_ready high only when idle)
//   key_in[127:0]       cipher key, sampled only on the accept edge
//   key_dec             reverse (decrypt) order request, sampled with key
//   rk_valid/rk_ready   round key handshake
//   rk_data[127:0]      round key, same word order as key_in
//   rk_index[3:0]       round number of rk_data
//   rk_last             marks the final key of a sequence
//
// Optional build macro AES_KEY_SCHED_DEC_EN: when defined, key_dec=1 makes
// the engine expand all keys into an internal buffer (FILL, two cycles per
// key, no output) and then emit them from index NROUNDS down to 0 (DRAIN).
// When undefined, key_dec is ignored and no buffer exists.

// One S-box byte lane: plain table lookup.
module aes_sbox_byte (
  input  logic [7:0] a,
  output logic [7:0] y
);
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };
  assign y = SBOX[a];
endmodule

// Four-lane S-box with a registered output (1-cycle latency).
module aes_sbox4 #(
  parameter int NUM_LANES = 4
) (
  input  logic                       clk,
  input  logic                       nreset,
  input  logic [NUM_LANES-1:0][7:0]  din,
  output logic [NUM_LANES-1:0][7:0]  dout
);
  logic [NUM_LANES-1:0][7:0] sub;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    aes_sbox_byte u_lane (.a(din[g]), .y(sub[g]));
  end

  always_ff @(posedge clk or negedge nreset)
    if (!nreset) dout <= '0;
    else         dout <= sub;
endmodule

module aes_key_sched #(
  parameter int NROUNDS = 10
) (
  input  logic         clk,
  input  logic         nreset,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic [127:0] key_in,
  input  logic         key_dec,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk_data,
  output logic [3:0]   rk_index,
  output logic         rk_last
);
  localparam logic [3:0] LAST = 4'(NROUNDS);

`ifdef AES_KEY_SCHED_DEC_EN
  typedef enum logic [2:0] {S_IDLE, S_EMIT, S_EXPAND, S_FILL, S_DRAIN} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_EMIT, S_EXPAND} state_t;
`endif

  state_t         state_q, state_d;
  logic [7:0]     rcon_q, rcon_nxt;
  logic [31:0]    s4_out, t;
  logic [127:0]   nk;
  logic           hs, acc;
  logic           ready_d, valid_d;

  assign hs  = rk_valid & rk_ready;
  assign acc = key_valid & key_ready;

  // SubWord(RotWord(w3)); rk_data is held in EMIT long enough for the
  // register inside aes_sbox4 to be current by the EXPAND cycle.
  aes_sbox4 u_s4 (
    .clk    (clk),
    .nreset (nreset),
    .din    ({rk_data[23:0], rk_data[31:24]}),
    .dout   (s4_out)
  );

  assign t        = s4_out ^ {rcon_q, 24'h0};
  assign nk[127:96] = rk_data[127:96] ^ t;
  assign nk[95:64]  = rk_data[95:64]  ^ nk[127:96];
  assign nk[63:32]  = rk_data[63:32]  ^ nk[95:64];
  assign nk[31:0]   = rk_data[31:0]   ^ nk[63:32];
  assign rcon_nxt   = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);

`ifdef AES_KEY_SCHED_DEC_EN
  logic         fill_ph;               // 0: S-box capture cycle, 1: expand
  logic [127:0] kbuf [0:NROUNDS];

  always_ff @(posedge clk) begin
    if (state_q == S_IDLE && acc)
      kbuf[0] <= key_in;
    if (state_q == S_FILL && fill_ph)
      kbuf[rk_index + 4'd1] <= nk;
  end
`else
  logic unused_dec;
  assign unused_dec = key_dec;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (acc) begin
`ifdef AES_KEY_SCHED_DEC_EN
        state_d = key_dec ? S_FILL : S_EMIT;
`else
        state_d = S_EMIT;
`endif
      end
      S_EMIT:   if (hs) state_d = (rk_index == LAST) ? S_IDLE : S_EXPAND;
      S_EXPAND: state_d = S_EMIT;
`ifdef AES_KEY_SCHED_DEC_EN
      S_FILL:   if (fill_ph && rk_index == LAST - 4'd1) state_d = S_DRAIN;
      S_DRAIN:  if (hs && rk_index == 4'd0) state_d = S_IDLE;
`endif
      default:  state_d = S_IDLE;
    endcase
    // handshake flags are registered copies of the next state
    ready_d = (state_d == S_IDLE);
    valid_d = (state_d == S_EMIT);
`ifdef AES_KEY_SCHED_DEC_EN
    valid_d = valid_d | (state_d == S_DRAIN);
`endif
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q   <= S_IDLE;
      key_ready <= 1'b1;
      rk_valid  <= 1'b0;
      rk_data   <= '0;
      rk_index  <= '0;
      rk_last   <= 1'b0;
      rcon_q    <= 8'h01;
`ifdef AES_KEY_SCHED_DEC_EN
      fill_ph   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      key_ready <= ready_d;
      rk_valid  <= valid_d;
      case (state_q)
        S_IDLE: if (acc) begin
          rk_data  <= key_in;
          rk_index <= '0;
          rk_last  <= 1'b0;
          rcon_q   <= 8'h01;
`ifdef AES_KEY_SCHED_DEC_EN
          fill_ph  <= 1'b0;
`endif
        end
        S_EMIT: if (hs && rk_index == LAST) rk_last <= 1'b0;
        S_EXPAND: begin
          rk_data  <= nk;
          rk_index <= rk_index + 4'd1;
          rk_last  <= (rk_index == LAST - 4'd1);
          rcon_q   <= rcon_nxt;
        end
`ifdef AES_KEY_SCHED_DEC_EN
        S_FILL: begin
          fill_ph <= ~fill_ph;
          if (fill_ph) begin
            rk_data  <= nk;
            rk_index <= rk_index + 4'd1;
            rcon_q   <= rcon_nxt;
          end
        end
        S_DRAIN: if (hs) begin
          if (rk_index != 4'd0) begin
            rk_data  <= kbuf[rk_index - 4'd1];
            rk_index <= rk_index - 4'd1;
            rk_last  <= (rk_index == 4'd1);
          end else begin
            rk_last  <= 1'b0;
          end
        end
`endif
        default: ;
      endcase
    end
  end
endmodule
